// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display path.
//   - Active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}, for hex digits 0..F and blank.
//   - digit_t: index of the currently scanned digit (0 = least significant nibble).
//   - disp_state_t: display FSM encoding (all anodes off / one digit lit).
//   - digit_anodes(): active-low one-hot anode pattern for a digit index.
package calc_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef logic [1:0] digit_t;

  typedef enum logic {
    StDead,
    StShow
  } disp_state_t;

  function automatic logic [3:0] digit_anodes(digit_t d);
    return ~(4'b0001 << d);
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
// Ports:
//   nib  in  4  hex digit value
//   seg  out 7  active-low segments {g,f,e,d,c,b,a}
module hex_to_seg
  import calc_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'ha: seg = SEG_A;
      4'hb: seg = SEG_B;
      4'hc: seg = SEG_C;
      4'hd: seg = SEG_D;
      4'he: seg = SEG_E;
      4'hf: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/calc_display.sv
// 4-digit time-multiplexed common-anode hex display for the 16-bit accumulator bus.
// A shadow register captures 'value' on 'load' so the scan never tears mid-update.
// Each digit is selected for REFRESH_DIV cycles; the first DEAD_CYCLES of them keep
// all anodes off to stop ghosting between digits. All display outputs are registered.
// Ports:
//   clk     in   1   system clock, rising edge
//   resetn  in   1   asynchronous active-low reset
//   value   in   16  accumulator value to show
//   load    in   1   capture strobe for value
//   an      out  4   active-low anodes, an[0] = least significant nibble
//   seg     out  7   active-low segments {g,f,e,d,c,b,a}
//   dp      out  1   active-low decimal point, held off
// Optional build macro: CALC_DISPLAY_LZ_BLANK_EN enables leading-zero blanking.
module calc_display
  import calc_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] value,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(REFRESH_DIV - 1);
  // Last div_cnt value spent blank; unused when DEAD_CYCLES is 0.
  localparam logic [CntW-1:0] DeadLast = (DEAD_CYCLES == 0) ? '0 : CntW'(DEAD_CYCLES - 1);

  logic [15:0]     shadow_q;
  logic [CntW-1:0] div_cnt_q;
  digit_t          digit_q;
  disp_state_t     state_q;
  logic [3:0]      an_q;
  logic [6:0]      seg_q;

  logic            term;
  digit_t          digit_nxt;
  logic [3:0]      nib_nxt;
  logic [6:0]      hex_seg;
  logic [6:0]      seg_nxt;
  logic [3:0]      an_nxt;

  // Outputs are registered, so the pattern is computed for the digit selected after this edge.
  always_comb begin
    term      = (div_cnt_q == TermCnt);
    digit_nxt = term ? digit_q + 2'd1 : digit_q;
    nib_nxt   = shadow_q[{digit_nxt, 2'b00} +: 4];
    an_nxt    = digit_anodes(digit_nxt);
  end

  hex_to_seg u_hex_to_seg (
    .nib (nib_nxt),
    .seg (hex_seg)
  );

`ifdef CALC_DISPLAY_LZ_BLANK_EN
  logic [3:0] nib_zero;
  logic [3:0] lz_blank;

  // Digit k blanks when it and every more significant nibble are zero; digit 0 never blanks.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      nib_zero[k] = (shadow_q[4*k +: 4] == 4'h0);
    end
    lz_blank[3] = nib_zero[3];
    lz_blank[2] = nib_zero[3] & nib_zero[2];
    lz_blank[1] = nib_zero[3] & nib_zero[2] & nib_zero[1];
    lz_blank[0] = 1'b0;
    seg_nxt     = lz_blank[digit_nxt] ? SEG_BLANK : hex_seg;
  end
`else
  assign seg_nxt = hex_seg;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow_q  <= 16'h0000;
      div_cnt_q <= '0;
      digit_q   <= '0;
      state_q   <= StDead;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
    end else begin
      if (load) begin
        shadow_q <= value;
      end
      div_cnt_q <= term ? '0 : div_cnt_q + CntW'(1);
      if (term) begin
        digit_q <= digit_nxt;
      end

      unique case (state_q)
        StDead: begin
          if (DEAD_CYCLES == 0 || div_cnt_q == DeadLast) begin
            state_q <= StShow;
            an_q    <= an_nxt;
            seg_q   <= seg_nxt;
          end
        end
        StShow: begin
          if (term && DEAD_CYCLES != 0) begin
            state_q <= StDead;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
          end else begin
            // Refreshed every cycle so a new shadow value appears one edge after capture.
            an_q  <= an_nxt;
            seg_q <= seg_nxt;
          end
        end
      endcase
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_calc_display.sv
// Scoreboard bench for calc_display (REFRESH_DIV=4, DEAD_CYCLES=1).
// The stimulus process pushes one expected {an,seg} frame per clock cycle; the monitor
// pops and compares one frame on every falling edge, and also checks anode one-hotness,
// dp and the 16-cycle scan period. Build with CALC_DISPLAY_LZ_BLANK_EN to cover blanking.
module tb_calc_display;

  localparam logic [6:0] BLANK = 7'b1111111;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } frame_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        load;
  logic [15:0] value;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  // Hand-written decode table, {g..a} active-low.
  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     last_d0 = -1;
  logic [3:0] prev_an = 4'b1111;

  always #5 clk = ~clk;

  calc_display #(
    .REFRESH_DIV (4),
    .DEAD_CYCLES (1)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .value  (value),
    .load   (load),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  function automatic logic [3:0] an_of(logic [1:0] d);
    logic [3:0] a;
    a    = 4'b1111;
    a[d] = 1'b0;
    return a;
  endfunction

  function automatic logic [6:0] exp_seg(logic [15:0] v, logic [1:0] d);
    logic [15:0] hi;
    hi = v >> {d, 2'b00};
`ifdef CALC_DISPLAY_LZ_BLANK_EN
    if (d != 2'd0 && hi == 16'h0000) return BLANK;
`endif
    return seg_tab[hi[3:0]];
  endfunction

  // Expected frame for the cycle that follows the next rising edge.
  task automatic cycle(input logic [3:0] a, input logic [6:0] s);
    @(posedge clk);
    #1;
    exp_q.push_back({a, s});
  endtask

  task automatic blank();
    cycle(4'b1111, BLANK);
  endtask

  task automatic show3(input logic [15:0] v, input logic [1:0] d);
    repeat (3) cycle(an_of(d), exp_seg(v, d));
  endtask

  task automatic slot(input logic [15:0] v, input logic [1:0] d);
    blank();
    show3(v, d);
  endtask

  // Monitor: frame compare, per-cycle invariants and scan period.
  always @(negedge clk) begin
    frame_t f;
    cyc++;
    checks++;
    if ($countones(~an) > 1 || dp !== 1'b1) begin
      errors++;
      $display("FAIL invariant@%0d: an=%b dp=%b, required at most one low anode and dp=1",
               cyc, an, dp);
    end
    if (exp_q.size() > 0) begin
      f = exp_q.pop_front();
      checks++;
      if ({an, seg} !== f) begin
        errors++;
        $display("FAIL frame@%0d: an=%b seg=%b, required an=%b seg=%b",
                 cyc, an, seg, f.an, f.seg);
      end
    end
    if (!resetn) begin
      last_d0 = -1;
    end else if (an == 4'b1110 && prev_an != 4'b1110) begin
      if (last_d0 >= 0) begin
        checks++;
        if (cyc - last_d0 != 16) begin
          errors++;
          $display("FAIL scan_period@%0d: got %0d cycles, required 16", cyc, cyc - last_d0);
        end
      end
      last_d0 = cyc;
    end
    prev_an = an;
  end

  initial begin
    resetn = 1'b1;
    load   = 1'b0;
    value  = 16'h0000;
    #2 resetn = 1'b0;
    repeat (3) blank();

    // Release, loading 0x1234 on the first edge; that edge still shows the old shadow (0).
    resetn = 1'b1;
    value  = 16'h1234;
    load   = 1'b1;
    cycle(4'b1110, 7'b1000000);
    load  = 1'b0;
    value = 16'h0000;
    cycle(4'b1110, 7'b0011001);
    cycle(4'b1110, 7'b0011001);
    slot(16'h1234, 2'd1);
    slot(16'h1234, 2'd2);
    slot(16'h1234, 2'd3);
    slot(16'h1234, 2'd0);

    // Capture 0xABCD, then present 0xFFFF without load: must never show.
    value = 16'hABCD;
    load  = 1'b1;
    blank();
    load  = 1'b0;
    value = 16'hFFFF;
    show3(16'hABCD, 2'd1);
    slot(16'hABCD, 2'd2);
    slot(16'hABCD, 2'd3);
    slot(16'hABCD, 2'd0);

    // Load on the digit-0 terminal-count edge.
    value = 16'h0008;
    load  = 1'b1;
    blank();
    load  = 1'b0;
    value = 16'h0000;
    show3(16'h0008, 2'd1);
    slot(16'h0008, 2'd2);
    slot(16'h0008, 2'd3);
    slot(16'h0008, 2'd0);
    slot(16'h0008, 2'd1);

    // Reset asserted while digit 2 is lit; outputs must blank before the next edge.
    blank();
    cycle(an_of(2'd2), exp_seg(16'h0008, 2'd2));
    cycle(an_of(2'd2), exp_seg(16'h0008, 2'd2));
    @(posedge clk);
    #1;
    resetn = 1'b0;
    exp_q.push_back({4'b1111, BLANK});
    blank();
    resetn = 1'b1;
    show3(16'h0000, 2'd0);
    slot(16'h0000, 2'd1);
    slot(16'h0000, 2'd2);
    slot(16'h0000, 2'd3);
    slot(16'h0000, 2'd0);

    // Leading zeros: blanked only when the build enables it.
    value = 16'h00A5;
    load  = 1'b1;
    blank();
    load  = 1'b0;
    show3(16'h00A5, 2'd1);
    slot(16'h00A5, 2'd2);
    slot(16'h00A5, 2'd3);
    slot(16'h00A5, 2'd0);
    value = 16'h0000;
    load  = 1'b1;
    blank();
    load  = 1'b0;
    show3(16'h0000, 2'd1);
    slot(16'h0000, 2'd2);
    slot(16'h0000, 2'd3);
    slot(16'h0000, 2'd0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d frames left unchecked, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_display.md
Name: calc_display

Overview:
- Output-side reader for the calculator's 16-bit accumulator/LED bus.
- Captures the 16-bit value and shows it as 4 hex digits on a time-multiplexed, common-anode 7-segment display.
- Sits between the calculator top level and the board display pins.
- Holds a shadow copy, so the display stays stable while the accumulator changes mid-scan.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays selected (must be >= 4).
- DEAD_CYCLES, 1: cycles all anodes are off at each digit change (anti-ghosting); 0 disables, must be < REFRESH_DIV.

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- value  input  16  accumulator value to show
- load  input  1  capture strobe; value sampled on a clk edge where load=1
- an  output  4  digit anodes, active-low; an[0] = least significant nibble
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low; always 1 (off) outside reset

Behaviour:
- Reset (resetn=0, async), regardless of any operation in progress:
  - shadow=16'h0000, div_cnt=0, digit=0, state=DEAD.
  - an=4'b1111, seg=7'b1111111, dp=1.
- Shadow register:
  - On a rising edge with load=1: shadow <= value.
  - A load in the same cycle as a digit change is still captured.
- Divider:
  - div_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - At the terminal count, digit <= digit+1 mod 4; digit 3 wraps to 0.
- State machine (2 states), all outputs registered:
  - DEAD: an=1111, seg=1111111. Stays for DEAD_CYCLES cycles from div_cnt=0, then goes to SHOW. With DEAD_CYCLES=0, DEAD is skipped.
  - SHOW: an = one-hot-low of digit; seg = decode(shadow[4*digit+3 -: 4]). At the terminal count, goes to DEAD (or stays in SHOW if DEAD_CYCLES=0).
- Decode table, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Latency:
  - load edge N updates shadow.
  - seg reflects the new nibble from edge N+1 if that digit is in SHOW.
- After reset release:
  - First DEAD_CYCLES cycles blank, then digit 0 is shown.
  - A full scan of all 4 digits takes 4*REFRESH_DIV cycles.
- Exactly one anode low at any time in SHOW; never more than one.

Optional Feature:
- Macro: CALC_DISPLAY_LZ_BLANK_EN
- Defined: leading-zero blanking on the shadow value.
  - Digit k is blanked (seg=1111111, anode still driven) when all nibbles at positions >= k are zero and k > 0.
  - Digit 0 is always shown, so 0x0000 shows a single "0".
  - Example: 0x00A5 shows blank, blank, A, 5.
- Undefined: all four digits always shown, including leading zeros.

Decomposition:
- Shared package calc_pkg:
  - Segment pattern constants SEG_0..SEG_F and SEG_BLANK.
  - Digit index type (2 bits).
  - Display state encoding (DEAD, SHOW).
- Sub-module hex_to_seg: combinational 4-bit nibble to 7-bit active-low pattern, implementing the decode table.
- Leading-zero logic stays in calc_display under the macro.

Test Plan (REFRESH_DIV=4, DEAD_CYCLES=1 for simulation):
- Reset, then release with value=16'h1234 and load=1 for one cycle.
  - Required: digit 0 shows an=1110, seg=0011001 (4); then an=1101 seg=0110000 (3); then an=1011 seg=0100100 (2); then an=0111 seg=1111001 (1).
  - Each digit is preceded by 1 blank cycle; the sequence then wraps to digit 0.
- Load 16'hABCD, then change value to 16'hFFFF with load=0.
  - Required: display stays A,b,C,d (digit 3 seg=0001000, digit 0 seg=0100001); 0xFFFF never appears.
- Pulse load with 16'h0008 in the cycle of a digit-0 terminal count.
  - Required: shadow updates.
  - Next time digit 0 is shown, seg=0000000.
- Assert resetn=0 mid-SHOW on digit 2.
  - Required: same cycle, asynchronously, an=1111, seg=1111111.
  - After release, scanning restarts at digit 0 with shadow=0 (seg=1000000).
- Every cycle:
  - Assert $countones(~an) <= 1 and dp=1.
  - Assert a full scan period of 16 cycles.
- With CALC_DISPLAY_LZ_BLANK_EN defined, load 16'h00A5.
  - Required: digits 3 and 2 show seg=1111111, digit 1 shows 0001000, digit 0 shows 0010010.
  - Load 16'h0000: only digit 0 shows 1000000.
